// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter for placer (p0), line clearer (p1) and display scanner (p2).
// Optional macro GRID_ARB_RR_EN selects round-robin between p0/p1; default is fixed p0 > p1.
module grid_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DISP_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p2_valid,
  input  logic [ADDR_W-1:0] p2_addr,
  output logic              p0_ready,
  output logic              p1_ready,
  output logic              p2_ready,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic              p2_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] grid_address,
  output logic [DATA_W-1:0] grid_data_out,
  output logic              write_en,
  input  logic [DATA_W-1:0] tetris_grid_in
);

  // owner    | meaning
  // OWN_NONE | free arbitration among valid requesters
  // OWN_P0   | p0 holds the memory until it issues a lock=0 beat
  // OWN_P1   | p1 holds the memory until it issues a lock=0 beat
  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

  localparam logic [3:0] LP_BURST = 4'(DISP_BURST);

  owner_t     r_owner;
  logic [3:0] r_disp_cnt;
  logic       r_tag_vld;
  logic [1:0] r_tag_port;

  logic w_game_v;
  logic w_disp_sat;
  logic w_pick_p1;
  logic w_acc0;
  logic w_acc1;
  logic w_acc2;

  assign w_game_v   = p0_valid | p1_valid;
  assign w_disp_sat = (r_disp_cnt == LP_BURST);

`ifdef GRID_ARB_RR_EN
  logic r_rr_ptr;  // 1 = p1 has priority on the next contested game grant

  assign w_pick_p1 = p1_valid & (r_rr_ptr | ~p0_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_rr_ptr <= 1'b0;
    else if (w_acc0) r_rr_ptr <= 1'b1;
    else if (w_acc1) r_rr_ptr <= 1'b0;
  end
`else
  assign w_pick_p1 = ~p0_valid;
`endif

  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    p2_ready = 1'b0;
    if (!reset) begin
      case (r_owner)
        OWN_P0: p0_ready = p0_valid;
        OWN_P1: p1_ready = p1_valid;
        default: begin
          if (p2_valid && !(w_disp_sat && w_game_v)) p2_ready = 1'b1;
          else if (w_game_v) begin
            if (w_pick_p1) p1_ready = 1'b1;
            else           p0_ready = 1'b1;
          end
        end
      endcase
    end
  end

  assign w_acc0 = p0_valid & p0_ready;
  assign w_acc1 = p1_valid & p1_ready;
  assign w_acc2 = p2_valid & p2_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= OWN_NONE;
      r_disp_cnt <= 4'd0;
    end else begin
      if (w_acc0)      r_owner <= p0_lock ? OWN_P0 : OWN_NONE;
      else if (w_acc1) r_owner <= p1_lock ? OWN_P1 : OWN_NONE;

      if (!w_game_v || w_acc0 || w_acc1)  r_disp_cnt <= 4'd0;
      else if (w_acc2 && !w_disp_sat)     r_disp_cnt <= r_disp_cnt + 4'd1;
    end
  end

  // Memory command stage; address/data hold on idle cycles, strobe drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid_address  <= '0;
      grid_data_out <= '0;
      write_en      <= 1'b0;
      r_tag_vld     <= 1'b0;
      r_tag_port    <= 2'd0;
    end else begin
      write_en  <= 1'b0;
      r_tag_vld <= 1'b0;
      if (w_acc0) begin
        grid_address  <= p0_addr;
        grid_data_out <= p0_wdata;
        write_en      <= p0_we;
        r_tag_vld     <= ~p0_we;
        r_tag_port    <= 2'd0;
      end else if (w_acc1) begin
        grid_address  <= p1_addr;
        grid_data_out <= p1_wdata;
        write_en      <= p1_we;
        r_tag_vld     <= ~p1_we;
        r_tag_port    <= 2'd1;
      end else if (w_acc2) begin
        grid_address  <= p2_addr;
        grid_data_out <= '0;
        r_tag_vld     <= 1'b1;
        r_tag_port    <= 2'd2;
      end
    end
  end

  // Read return stage: RAM data for last cycle's address is captured here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p2_rvalid <= 1'b0;
      rdata     <= '0;
    end else begin
      p0_rvalid <= r_tag_vld && (r_tag_port == 2'd0);
      p1_rvalid <= r_tag_vld && (r_tag_port == 2'd1);
      p2_rvalid <= r_tag_vld && (r_tag_port == 2'd2);
      if (r_tag_vld) rdata <= tetris_grid_in;
    end
  end

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Randomized + directed bench for grid_mem_arbiter against a transaction-level reference model.
module tb_grid_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_valid, p0_we, p0_lock, p1_valid, p1_we, p1_lock, p2_valid;
  logic [AW-1:0] p0_addr, p1_addr, p2_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ready, p1_ready, p2_ready, p0_rvalid, p1_rvalid, p2_rvalid;
  logic [DW-1:0] rdata, grid_data_out, tetris_grid_in;
  logic [AW-1:0] grid_address;
  logic          write_en;

  logic [DW-1:0] mem [256];
  assign tetris_grid_in = mem[grid_address];

  always #5 clk = ~clk;

  grid_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DISP_BURST(DB)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p2_valid(p2_valid), .p2_addr(p2_addr),
    .p0_ready(p0_ready), .p1_ready(p1_ready), .p2_ready(p2_ready),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid), .p2_rvalid(p2_rvalid),
    .rdata(rdata), .grid_address(grid_address), .grid_data_out(grid_data_out),
    .write_en(write_en), .tetris_grid_in(tetris_grid_in)
  );

  int n_vec = 0;
  int n_fail = 0;

  // Reference model state: owner 0=none,1=p0,2=p1
  int            m_owner, m_cnt, m_rr;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, e_rdata, pipe_data;
  int            pipe_port;   // -1 = no read in flight
  int            ret_port;    // port whose rvalid is expected now, -1 = none
  logic [2:0]    obs_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_rr = 0;
    e_we = 1'b0; e_addr = '0; e_data = '0; e_rdata = '0;
    pipe_port = -1; ret_port = -1;
  endtask

  task automatic clear_in();
    p0_valid = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_valid = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    p2_valid = 0; p2_addr = '0;
  endtask

  // Entered at posedge+1 with inputs set; checks at posedge+3, returns at next posedge+1.
  task automatic cycle();
    int w;
    bit gv;
    int new_port;
    logic [DW-1:0] new_data;
    #2;
    gv = p0_valid | p1_valid;
    w = -1;
    if (m_owner == 1) begin
      if (p0_valid) w = 0;
    end else if (m_owner == 2) begin
      if (p1_valid) w = 1;
    end else if (p2_valid && !(m_cnt == DB && gv)) w = 2;
    else if (gv) begin
`ifdef GRID_ARB_RR_EN
      w = (p0_valid && p1_valid) ? m_rr : (p0_valid ? 0 : 1);
`else
      w = p0_valid ? 0 : 1;
`endif
    end
    obs_ready = {p2_ready, p1_ready, p0_ready};
    chk("p0_ready", 32'(p0_ready), 32'(w == 0));
    chk("p1_ready", 32'(p1_ready), 32'(w == 1));
    chk("p2_ready", 32'(p2_ready), 32'(w == 2));
    chk("write_en", 32'(write_en), 32'(e_we));
    chk("grid_address", 32'(grid_address), 32'(e_addr));
    chk("grid_data_out", 32'(grid_data_out), 32'(e_data));
    chk("p0_rvalid", 32'(p0_rvalid), 32'(ret_port == 0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(ret_port == 1));
    chk("p2_rvalid", 32'(p2_rvalid), 32'(ret_port == 2));
    if (ret_port >= 0) chk("rdata", 32'(rdata), 32'(e_rdata));
    @(posedge clk);
    #1;
    new_port = -1;
    new_data = '0;
    e_we = 1'b0;
    if (w == 0) begin
      e_we = p0_we; e_addr = p0_addr; e_data = p0_wdata;
      if (!p0_we) begin new_port = 0; new_data = mem[p0_addr]; end
      m_owner = p0_lock ? 1 : 0;
      m_rr = 1;
    end else if (w == 1) begin
      e_we = p1_we; e_addr = p1_addr; e_data = p1_wdata;
      if (!p1_we) begin new_port = 1; new_data = mem[p1_addr]; end
      m_owner = p1_lock ? 2 : 0;
      m_rr = 0;
    end else if (w == 2) begin
      e_addr = p2_addr; e_data = '0;
      new_port = 2; new_data = mem[p2_addr];
    end
    if (!gv || w == 0 || w == 1) m_cnt = 0;
    else if (w == 2 && m_cnt < DB) m_cnt++;
    ret_port = pipe_port;
    if (pipe_port >= 0) e_rdata = pipe_data;
    pipe_port = new_port;
    pipe_data = new_data;
  endtask

  initial begin
    int gnt0, gnt1;
    int lk[5] = '{1, 1, -1, 1, 0};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h30] = 8'h7E;
    clear_in();
    model_reset();
    reset = 1'b1;
    p0_valid = 1'b1;
    #12;
    chk("rst_p0_ready", 32'(p0_ready), 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_grid_address", 32'(grid_address), 32'd0);
    chk("rst_grid_data_out", 32'(grid_data_out), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rvalid", 32'({p2_rvalid, p1_rvalid, p0_rvalid}), 32'd0);
    reset = 1'b0;
    clear_in();
    @(posedge clk);
    #1;

    // p0 write 0x12 <- 0xA5
    p0_valid = 1; p0_we = 1; p0_addr = 8'h12; p0_wdata = 8'hA5;
    cycle();
    clear_in();
    cycle(); cycle();

    // p2 read of 0x30
    p2_valid = 1; p2_addr = 8'h30;
    cycle();
    clear_in();
    cycle(); cycle(); cycle();

    // p0 locked burst with a valid gap, p1 and p2 contending
    p1_valid = 1; p1_addr = 8'h21; p2_valid = 1; p2_addr = 8'h40;
    for (int i = 0; i < 5; i++) begin
      p0_valid = (lk[i] >= 0); p0_we = 1; p0_lock = (lk[i] == 1);
      p0_addr = 8'(8'h50 + i); p0_wdata = 8'($urandom);
      cycle();
    end
    p0_valid = 0;
    cycle();
    clear_in();
    cycle(); cycle();

    // display burst limit: expect 8 p2 then 1 p0, repeating
    gnt0 = 0;
    p0_valid = 1; p2_valid = 1;
    for (int i = 0; i < 27; i++) begin
      p0_addr = 8'($urandom); p2_addr = 8'($urandom);
      cycle();
      gnt0 += int'(obs_ready[0]);
    end
    chk("burst_p0_grants", 32'(gnt0), 32'(27 / (DB + 1)));
    clear_in();
    cycle(); cycle();

    // p0/p1 contention, display idle
    gnt1 = 0;
    p0_valid = 1; p1_valid = 1;
    for (int i = 0; i < 8; i++) begin
      p0_addr = 8'($urandom); p1_addr = 8'($urandom);
      cycle();
      gnt1 += int'(obs_ready[1]);
    end
`ifdef GRID_ARB_RR_EN
    chk("rr_p1_grants", 32'(gnt1), 32'd4);
`else
    chk("fixed_p1_grants", 32'(gnt1), 32'd0);
`endif
    clear_in();
    cycle(); cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      p0_valid = ($urandom_range(0, 2) != 0); p0_we = 1'($urandom); p0_lock = ($urandom_range(0, 3) == 0);
      p0_addr = 8'($urandom); p0_wdata = 8'($urandom);
      p1_valid = ($urandom_range(0, 2) != 0); p1_we = 1'($urandom); p1_lock = ($urandom_range(0, 3) == 0);
      p1_addr = 8'($urandom); p1_wdata = 8'($urandom);
      p2_valid = 1'($urandom); p2_addr = 8'($urandom);
      cycle();
    end

    // release any ownership, then drain
    p0_valid = 1; p0_we = 1; p1_valid = 1; p1_we = 1;
    cycle(); cycle();
    clear_in();
    cycle(); cycle(); cycle();

    // p1 read then reset mid-flight
    p1_valid = 1; p1_addr = 8'h44;
    cycle();
    clear_in();
    p0_valid = 1;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_write_en", 32'(write_en), 32'd0);
    chk("midrst_grid_address", 32'(grid_address), 32'd0);
    chk("midrst_ready", 32'({p2_ready, p1_ready, p0_ready}), 32'd0);
    chk("midrst_rvalid", 32'({p2_rvalid, p1_rvalid, p0_rvalid}), 32'd0);
    model_reset();
    #2;
    reset = 1'b0;
    clear_in();
    @(posedge clk);
    #1;
    p0_valid = 1; p0_addr = 8'h5A;
    cycle();
    clear_in();
    cycle(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
